// File: rtl/lcd_pkg.sv
// Shared LCD definitions: character geometry, ASCII constants and
// the word-builder state encoding, also used by the LCD writer.
package lcd_pkg;

    localparam int CHAR_W   = 8;
    localparam int WORD_LEN = 10;
    localparam int DIGITS   = 5;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FORMAT
    } state_t;

    function automatic logic [7:0] bcd_char(input logic [3:0] nib);
        return ASCII_ZERO + {4'h0, nib};
    endfunction

endpackage

// File: rtl/lcd_bin2bcd.sv
// Iterative double-dabble: 16-bit binary to 5 BCD nibbles, one bit
// per clock, with a shift counter and a last-shift flag.
module lcd_bin2bcd
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        shift_en,
    input  logic [15:0] value,
    output logic [19:0] bcd,
    output logic        last
);

    logic [15:0] shreg;
    logic [4:0]  cnt;
    logic [19:0] adj;

    // Add-3 correction of every nibble that would overflow on shift.
    always_comb begin
        adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    assign last = (cnt == 5'd1);

    // Load a new operand or shift the combined BCD/binary register.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= value;
            bcd   <= '0;
            cnt   <= 5'd16;
        end else if (shift_en) begin
            {bcd, shreg} <= {adj[18:0], shreg, 1'b0};
            cnt          <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/lcd_word_builder.sv
// Builds the 10-char LCD word "<LABEL><5 digits>" from a 16-bit value.
// Define LCD_LZB_EN to blank leading zeros among the first four digits.
module lcd_word_builder
    import lcd_pkg::*;
#(
    parameter logic [39:0] LABEL = 40'h203A4C4156
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [79:0] word
);

`ifdef LCD_LZB_EN
    localparam logic [39:0] RST_DIGITS = 40'h3020202020;
`else
    localparam logic [39:0] RST_DIGITS = 40'h3030303030;
`endif

    state_t      state;
    state_t      next_state;
    logic        load;
    logic        shift_en;
    logic        fmt_en;
    logic        last;
    logic [19:0] bcd;
    logic [39:0] digits;
    logic [39:0] fmt_digits;

    lcd_bin2bcd u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .value    (value),
        .bcd      (bcd),
        .last     (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state and datapath strobes.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        fmt_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last)
                    next_state = FORMAT;
            end
            FORMAT: begin
                fmt_en     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Digit characters; char 5 (most significant) in the low byte.
    always_comb begin
        logic       blank;
        logic [3:0] nib;
        logic [7:0] ch;
        fmt_digits = '0;
        blank      = 1'b1;
        nib        = '0;
        ch         = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nib = bcd[4*(DIGITS-1-k) +: 4];
            ch  = bcd_char(nib);
`ifdef LCD_LZB_EN
            if (k < DIGITS - 1 && blank && nib == 4'd0)
                ch = ASCII_SPACE;
            else
                blank = 1'b0;
`else
            blank = 1'b0;
`endif
            fmt_digits[8*k +: 8] = ch;
        end
    end

    // Digit field register and the done pulse, both set in FORMAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits <= RST_DIGITS;
            done   <= 1'b0;
        end else begin
            done <= fmt_en;
            if (fmt_en)
                digits <= fmt_digits;
        end
    end

    assign busy = (state != IDLE);
    assign word = {digits, LABEL};

endmodule

// File: tb/tb_lcd_word_builder.sv
// Self-checking bench for lcd_word_builder: table-driven conversions
// plus ignored-start, held-start and mid-conversion reset sequences.
module tb_lcd_word_builder;

    localparam logic [39:0] LBL = 40'h203A4C4156;
`ifdef LCD_LZB_EN
    localparam logic [39:0] RST_HI = 40'h3020202020;
`else
    localparam logic [39:0] RST_HI = 40'h3030303030;
`endif

    typedef struct {
        logic [15:0] val;
        logic [39:0] hi;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        start;
    logic        busy;
    logic        done;
    logic [79:0] word;

    int checks = 0;
    int errors = 0;

    lcd_word_builder dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .start (start),
        .busy  (busy),
        .done  (done),
        .word  (word)
    );

    always #5 clk = ~clk;

    // Concurrent invariant: busy and done never high together.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=%b done=%b", busy, done);
            end
        end
    end

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_conv(input logic [15:0] v, input logic [39:0] hi);
        int lat;
        int bcnt;
        int wchg;
        logic [79:0] prev;
        prev  = word;
        value = v;
        start = 1'b1;
        step();
        start = 1'b0;
        value = 16'hFFFF;
        chk("busy_after_start", {79'd0, busy}, 80'd1);
        lat  = 0;
        bcnt = 1;
        wchg = 0;
        while (lat < 40) begin
            step();
            lat++;
            if (done) break;
            if (busy) bcnt++;
            if (word !== prev) wchg++;
        end
        chk("latency", 80'(lat), 80'd17);
        chk("busy_cycles", 80'(bcnt), 80'd17);
        chk("word_stable", 80'(wchg), 80'd0);
        chk("word", word, {hi, LBL});
        step();
        chk("done_pulse", {79'd0, done}, 80'd0);
    endtask

    vec_t vt[$];

    initial begin
        int dcnt;
`ifdef LCD_LZB_EN
        vt.push_back('{16'd12345, 40'h3534333231});
        vt.push_back('{16'd65535, 40'h3533353536});
        vt.push_back('{16'd0,     40'h3020202020});
        vt.push_back('{16'd1000,  40'h3030303120});
        vt.push_back('{16'd7,     40'h3720202020});
        vt.push_back('{16'd10050, 40'h3035303031});
        vt.push_back('{16'd99,    40'h3939202020});
`else
        vt.push_back('{16'd12345, 40'h3534333231});
        vt.push_back('{16'd65535, 40'h3533353536});
        vt.push_back('{16'd0,     40'h3030303030});
        vt.push_back('{16'd1000,  40'h3030303130});
        vt.push_back('{16'd7,     40'h3730303030});
        vt.push_back('{16'd10050, 40'h3035303031});
        vt.push_back('{16'd99,    40'h3939303030});
`endif
        reset = 1'b1;
        value = '0;
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("reset_word", word, {RST_HI, LBL});
        chk("reset_busy", {79'd0, busy}, 80'd0);
        chk("reset_done", {79'd0, done}, 80'd0);

        foreach (vt[i]) run_conv(vt[i].val, vt[i].hi);

        // Second start mid-conversion is ignored.
        value = 16'd12345;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        value = 16'd999;
        start = 1'b1;
        step();
        start = 1'b0;
        dcnt = 0;
        repeat (25) begin
            step();
            if (done) dcnt++;
        end
        chk("ignored_start_dones", 80'(dcnt), 80'd1);
        chk("ignored_start_word", word, {40'h3534333231, LBL});

        // Start held high re-triggers straight out of the done cycle.
        value = 16'd7;
        start = 1'b1;
        dcnt  = 0;
        while (!done && dcnt < 40) begin
            step();
            dcnt++;
        end
        chk("held_first_done", {79'd0, done}, 80'd1);
        step();
        start = 1'b0;
        chk("held_retrigger_busy", {79'd0, busy}, 80'd1);
        repeat (20) step();
        chk("held_idle", {79'd0, busy}, 80'd0);

        // Reset in the middle of a conversion aborts it.
        value = 16'd54321;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_word", word, {RST_HI, LBL});
        chk("abort_busy", {79'd0, busy}, 80'd0);
        dcnt = 0;
        repeat (25) begin
            step();
            if (done) dcnt++;
        end
        chk("abort_no_done", 80'(dcnt), 80'd0);
        chk("abort_word_held", word, {RST_HI, LBL});
        run_conv(16'd54321, 40'h3132333435);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
